// File: rtl/reg_bus_ctrl.sv
// Bus transfer sequencer and two-port arbiter for a tri-state register bank.
// Ports:
//   CLK, CLR (sync high)
//   REQ/SRC/DST/EXT/DIN _A/_B  : requests
//   GNT_x, DONE_x              : grant and done pulse
//   OE, LD, EXT_OE, EXT_D, BUSY : bus controls
// Build option: define RR_ARB_EN for round-robin arbitration
//   (default is fixed priority, with A winning).
module reg_bus_ctrl #(
    parameter int NREG = 4,
    parameter int W    = 4,
    parameter int AW   = 2
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            REQ_A,
    input  logic [AW-1:0]   SRC_A,
    input  logic [AW-1:0]   DST_A,
    input  logic            EXT_A,
    input  logic [W-1:0]    DIN_A,
    input  logic            REQ_B,
    input  logic [AW-1:0]   SRC_B,
    input  logic [AW-1:0]   DST_B,
    input  logic            EXT_B,
    input  logic [W-1:0]    DIN_B,
    output logic            GNT_A,
    output logic            GNT_B,
    output logic            DONE_A,
    output logic            DONE_B,
    output logic [NREG-1:0] OE,
    output logic [NREG-1:0] LD,
    output logic            EXT_OE,
    output logic [W-1:0]    EXT_D,
    output logic            BUSY
);

    typedef enum logic [1:0] {
        S_IDLE, S_DRIVE, S_LATCH, S_DONE
    } state_t;

    state_t          state, state_nx;
    logic            own_b, own_b_nx;
    logic [AW-1:0]   src, src_nx, dst, dst_nx;
    logic            ext, ext_nx;
    logic [W-1:0]    din, din_nx;
    logic            pick_b;

    logic [NREG-1:0] oe_nx, ld_nx, src_dec;
    logic            ext_oe_nx, gnt_a_nx, gnt_b_nx;
    logic            done_a_nx, done_b_nx, busy_nx;
    logic [W-1:0]    ext_d_nx;

    // One-hot decode; indices >= NREG decode to zero.
    function automatic logic [NREG-1:0] dec(input logic [AW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++)
            if (idx == AW'(i)) v[i] = 1'b1;
        return v;
    endfunction

`ifdef RR_ARB_EN
    // prio_b set means B wins the next tie.
    logic prio_b;

    assign pick_b = REQ_B & (~REQ_A | prio_b);

    always_ff @(posedge CLK) begin
        if (CLR)
            prio_b <= 1'b0;
        else if (state == S_IDLE && (REQ_A || REQ_B))
            prio_b <= ~pick_b;
    end
`else
    assign pick_b = REQ_B & ~REQ_A;
`endif

    always_comb begin
        state_nx = state;
        own_b_nx = own_b;
        src_nx   = src;
        dst_nx   = dst;
        ext_nx   = ext;
        din_nx   = din;

        unique case (state)
            S_IDLE: begin
                if (REQ_A || REQ_B) begin
                    own_b_nx = pick_b;
                    src_nx   = pick_b ? SRC_B : SRC_A;
                    dst_nx   = pick_b ? DST_B : DST_A;
                    ext_nx   = pick_b ? EXT_B : EXT_A;
                    din_nx   = pick_b ? DIN_B : DIN_A;
                    // Register-to-itself copy skips the bus entirely.
                    if (!ext_nx && src_nx == dst_nx)
                        state_nx = S_DONE;
                    else
                        state_nx = S_DRIVE;
                end
            end
            S_DRIVE: state_nx = S_LATCH;
            S_LATCH: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are precomputed from the next state and registered.
    always_comb begin
        oe_nx     = '1;
        ld_nx     = '0;
        ext_oe_nx = 1'b0;
        ext_d_nx  = '0;
        gnt_a_nx  = 1'b0;
        gnt_b_nx  = 1'b0;
        done_a_nx = 1'b0;
        done_b_nx = 1'b0;
        busy_nx   = (state_nx != S_IDLE);
        src_dec   = dec(src_nx);

        if (state_nx == S_DRIVE || state_nx == S_LATCH) begin
            if (ext_nx) begin
                ext_oe_nx = 1'b1;
                ext_d_nx  = din_nx;
            end else begin
                oe_nx = ~src_dec;
            end
        end

        // No load unless something actually drives the bus.
        if (state_nx == S_LATCH && (ext_nx || (|src_dec)))
            ld_nx = dec(dst_nx);

        if (state_nx != S_IDLE) begin
            gnt_a_nx = ~own_b_nx;
            gnt_b_nx = own_b_nx;
        end

        if (state_nx == S_DONE) begin
            done_a_nx = ~own_b_nx;
            done_b_nx = own_b_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= S_IDLE;
            own_b  <= 1'b0;
            src    <= '0;
            dst    <= '0;
            ext    <= 1'b0;
            din    <= '0;
            OE     <= '1;
            LD     <= '0;
            EXT_OE <= 1'b0;
            EXT_D  <= '0;
            GNT_A  <= 1'b0;
            GNT_B  <= 1'b0;
            DONE_A <= 1'b0;
            DONE_B <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_nx;
            own_b  <= own_b_nx;
            src    <= src_nx;
            dst    <= dst_nx;
            ext    <= ext_nx;
            din    <= din_nx;
            OE     <= oe_nx;
            LD     <= ld_nx;
            EXT_OE <= ext_oe_nx;
            EXT_D  <= ext_d_nx;
            GNT_A  <= gnt_a_nx;
            GNT_B  <= gnt_b_nx;
            DONE_A <= done_a_nx;
            DONE_B <= done_b_nx;
            BUSY   <= busy_nx;
        end
    end

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Testbench for reg_bus_ctrl: directed transfer table plus
// arbitration and mid-transfer reset sequences.
module tb_reg_bus_ctrl;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       REQ_A, EXT_A, REQ_B, EXT_B;
    logic [1:0] SRC_A, DST_A, SRC_B, DST_B;
    logic [3:0] DIN_A, DIN_B;
    logic       GNT_A, GNT_B, DONE_A, DONE_B, EXT_OE, BUSY;
    logic [3:0] OE, LD, EXT_D;

    int checks = 0;
    int errors = 0;

    reg_bus_ctrl #(.NREG(4), .W(4), .AW(2)) dut (
        .CLK(CLK), .CLR(CLR),
        .REQ_A(REQ_A), .SRC_A(SRC_A), .DST_A(DST_A),
        .EXT_A(EXT_A), .DIN_A(DIN_A),
        .REQ_B(REQ_B), .SRC_B(SRC_B), .DST_B(DST_B),
        .EXT_B(EXT_B), .DIN_B(DIN_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B),
        .DONE_A(DONE_A), .DONE_B(DONE_B),
        .OE(OE), .LD(LD), .EXT_OE(EXT_OE), .EXT_D(EXT_D),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       b;
        logic       ext;
        logic [1:0] src;
        logic [1:0] dst;
        logic [3:0] din;
        logic       noop;
        logic [3:0] oe_drv;
        logic [3:0] ld_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_outs(input string nm);
        chk({nm, " OE"}, 32'(OE), 32'hF);
        chk({nm, " LD"}, 32'(LD), 32'h0);
        chk({nm, " EXT_OE"}, 32'(EXT_OE), 32'h0);
        chk({nm, " EXT_D"}, 32'(EXT_D), 32'h0);
        chk({nm, " GNT"}, 32'({GNT_A, GNT_B}), 32'h0);
        chk({nm, " DONE"}, 32'({DONE_A, DONE_B}), 32'h0);
        chk({nm, " BUSY"}, 32'(BUSY), 32'h0);
    endtask

    task automatic set_port(input logic b, input logic req,
                            input logic ext, input logic [1:0] src,
                            input logic [1:0] dst, input logic [3:0] din);
        if (b) begin
            REQ_B = req; EXT_B = ext; SRC_B = src;
            DST_B = dst; DIN_B = din;
        end else begin
            REQ_A = req; EXT_A = ext; SRC_A = src;
            DST_A = dst; DIN_A = din;
        end
    endtask

    logic [1:0] gexp;
    logic [1:0] arb_exp[3];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 2'd0, 2'd2, 4'b0101, 1'b0,
                    4'b1111, 4'b0100};
        vecs[1] = '{1'b0, 1'b0, 2'd1, 2'd3, 4'b0000, 1'b0,
                    4'b1101, 4'b1000};
        vecs[2] = '{1'b0, 1'b0, 2'd2, 2'd2, 4'b0000, 1'b1,
                    4'b1111, 4'b0000};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 2'd1, 4'b0000, 1'b0,
                    4'b1110, 4'b0010};
        vecs[4] = '{1'b1, 1'b1, 2'd3, 2'd0, 4'b1010, 1'b0,
                    4'b1111, 4'b0001};
        vecs[5] = '{1'b1, 1'b0, 2'd3, 2'd0, 4'b0000, 1'b0,
                    4'b0111, 4'b0001};

`ifdef RR_ARB_EN
        arb_exp = '{2'b10, 2'b01, 2'b10};
`else
        arb_exp = '{2'b10, 2'b10, 2'b10};
`endif

        CLR = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
        set_port(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
        step();
        step();
        idle_outs("reset");
        CLR = 1'b0;
        step();
        idle_outs("post_reset");

        foreach (vecs[i]) begin
            gexp = vecs[i].b ? 2'b01 : 2'b10;
            set_port(vecs[i].b, 1'b1, vecs[i].ext, vecs[i].src,
                     vecs[i].dst, vecs[i].din);
            step();
            if (vecs[i].noop) begin
                chk($sformatf("v%0d noop DONE", i),
                    32'({DONE_A, DONE_B}), 32'(gexp));
                chk($sformatf("v%0d noop GNT", i),
                    32'({GNT_A, GNT_B}), 32'(gexp));
                chk($sformatf("v%0d noop OE", i), 32'(OE), 32'hF);
                chk($sformatf("v%0d noop LD", i), 32'(LD), 32'h0);
                chk($sformatf("v%0d noop EXT_OE", i),
                    32'(EXT_OE), 32'h0);
                set_port(vecs[i].b, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
                step();
                idle_outs($sformatf("v%0d noop end", i));
            end else begin
                chk($sformatf("v%0d drv OE", i),
                    32'(OE), 32'(vecs[i].oe_drv));
                chk($sformatf("v%0d drv EXT_OE", i),
                    32'(EXT_OE), 32'(vecs[i].ext));
                chk($sformatf("v%0d drv EXT_D", i), 32'(EXT_D),
                    32'(vecs[i].ext ? vecs[i].din : 4'd0));
                chk($sformatf("v%0d drv LD", i), 32'(LD), 32'h0);
                chk($sformatf("v%0d drv GNT", i),
                    32'({GNT_A, GNT_B}), 32'(gexp));
                chk($sformatf("v%0d drv BUSY", i), 32'(BUSY), 32'h1);
                // Drop request and scramble fields mid-transfer.
                set_port(vecs[i].b, 1'b0, ~vecs[i].ext, ~vecs[i].src,
                         ~vecs[i].dst, ~vecs[i].din);
                step();
                chk($sformatf("v%0d lat OE", i),
                    32'(OE), 32'(vecs[i].oe_drv));
                chk($sformatf("v%0d lat EXT_D", i), 32'(EXT_D),
                    32'(vecs[i].ext ? vecs[i].din : 4'd0));
                chk($sformatf("v%0d lat LD", i),
                    32'(LD), 32'(vecs[i].ld_lat));
                chk($sformatf("v%0d lat DONE", i),
                    32'({DONE_A, DONE_B}), 32'h0);
                step();
                chk($sformatf("v%0d done DONE", i),
                    32'({DONE_A, DONE_B}), 32'(gexp));
                chk($sformatf("v%0d done GNT", i),
                    32'({GNT_A, GNT_B}), 32'(gexp));
                chk($sformatf("v%0d done OE", i), 32'(OE), 32'hF);
                chk($sformatf("v%0d done LD", i), 32'(LD), 32'h0);
                chk($sformatf("v%0d done EXT_OE", i),
                    32'(EXT_OE), 32'h0);
                step();
                idle_outs($sformatf("v%0d idle", i));
            end
        end

        // Both ports requesting continuously from a fresh reset.
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        set_port(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 4'b0001);
        set_port(1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 4'b0010);
        for (int t = 0; t < 3; t++) begin
            step();
            chk($sformatf("arb%0d GNT", t),
                32'({GNT_A, GNT_B}), 32'(arb_exp[t]));
            chk($sformatf("arb%0d EXT_D", t), 32'(EXT_D),
                32'(arb_exp[t][1] ? 4'b0001 : 4'b0010));
            step();
            chk($sformatf("arb%0d LD", t), 32'(LD),
                32'(arb_exp[t][1] ? 4'b0001 : 4'b0010));
            step();
            chk($sformatf("arb%0d DONE", t),
                32'({DONE_A, DONE_B}), 32'(arb_exp[t]));
            step();
            chk($sformatf("arb%0d idle BUSY", t), 32'(BUSY), 32'h0);
        end
        set_port(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
        set_port(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
        step();
        idle_outs("arb end");

        // Reset arriving during the latch cycle.
        set_port(1'b0, 1'b1, 1'b0, 2'd1, 2'd3, 4'd0);
        step();
        chk("clr drv OE", 32'(OE), 32'hD);
        REQ_A = 1'b0;
        step();
        chk("clr lat LD", 32'(LD), 32'h8);
        CLR = 1'b1;
        step();
        idle_outs("clr abort");
        CLR = 1'b0;
        step();
        idle_outs("clr after");
        step();
        idle_outs("clr after2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
